// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : mode encodings and state type for updown_mode_counter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cnt_state_e;

    // Mode 2'b11 is an alias of wrap, so only one-shot needs an explicit test.
    function automatic logic is_oneshot(input logic [1:0] mode);
        return (mode == MODE_ONESHOT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler : clock-enable divider, one step_en every prescale+1 en cycles
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  hard_rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  step_en
);

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;
    logic                  w_at_top;

    assign w_at_top = (pre_q == prescale);
    assign step_en  = en && w_at_top;

    // Lowering prescale below pre_q lets the counter run on through all-ones.
    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = w_at_top ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/updown_mode_counter.sv
// ============================================================================
// updown_mode_counter : up/down bounded counter, wrap/saturate/one-shot modes,
//                       parallel load and built-in prescaler
// Revision            : 1.0
// ============================================================================
`default_nettype none

module updown_mode_counter #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  hard_rst_n,
    input  logic                  soft_rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      low_val,
    input  logic [WIDTH-1:0]      end_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clr_ovf,
    output logic [WIDTH-1:0]      cnt_out,
    output logic                  tc,
    output logic                  done,
    output logic                  ovf,
    output logic                  cfg_err
);

    import counter_pkg::*;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    cnt_state_e       state_q, state_d;

    logic             w_cfg_err;
    logic [WIDTH-1:0] w_start;
    logic [WIDTH-1:0] w_term_val;
    logic             w_out_of_range;
    logic             w_at_term;
    logic             w_pre_en;
    logic             w_tick;
    logic             w_step;
    logic             w_ovf_set;

    assign w_cfg_err      = (low_val > end_val);
    assign w_start        = up_dn ? low_val : end_val;
    assign w_term_val     = up_dn ? end_val : low_val;
    // A count pushed outside the bounds by a load or bound change ends the run.
    assign w_out_of_range = (cnt_q < low_val) || (cnt_q > end_val);
    assign w_at_term      = (up_dn ? (cnt_q >= end_val) : (cnt_q <= low_val))
                            || w_out_of_range;

    assign w_pre_en = en && (state_q == ST_RUN);
    assign w_step   = w_tick && !w_cfg_err && !soft_rst && !load;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .hard_rst_n (hard_rst_n),
        .clear      (soft_rst || load),
        .en         (w_pre_en),
        .prescale   (prescale),
        .step_en    (w_tick)
    );

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        tc_d      = 1'b0;
        w_ovf_set = 1'b0;
        if (soft_rst) begin
            cnt_d   = w_start;
            state_d = ST_RUN;
        end else if (load) begin
            cnt_d   = load_val;
            state_d = ST_RUN;
        end else if (w_step) begin
            if (w_at_term) begin
                tc_d = 1'b1;
                if (is_oneshot(mode)) begin
                    cnt_d   = w_term_val;
                    state_d = ST_DONE;
                end else if (mode == MODE_SAT) begin
                    cnt_d     = w_term_val;
                    w_ovf_set = 1'b1;
                end else begin
                    cnt_d     = w_start;
                    w_ovf_set = 1'b1;
                end
            end else begin
                cnt_d = up_dn ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
            end
        end
        ovf_d = ovf_q;
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tc      = tc_q;
    assign done    = (state_q == ST_DONE);
    assign ovf     = ovf_q;
    assign cfg_err = w_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_updown_mode_counter.sv
// ============================================================================
// tb_updown_mode_counter : directed bench with a rule-level reference model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_updown_mode_counter;

    localparam int WIDTH = 4;
    localparam int PW    = 8;

    logic             clk        = 1'b0;
    logic             hard_rst_n = 1'b0;
    logic             soft_rst   = 1'b0;
    logic             en         = 1'b0;
    logic             up_dn      = 1'b1;
    logic [1:0]       mode       = 2'b00;
    logic [WIDTH-1:0] low_val    = 4'd2;
    logic [WIDTH-1:0] end_val    = 4'd5;
    logic [PW-1:0]    prescale   = 8'd0;
    logic             load       = 1'b0;
    logic [WIDTH-1:0] load_val   = 4'd0;
    logic             clr_ovf    = 1'b0;
    logic [WIDTH-1:0] cnt_out;
    logic             tc, done, ovf, cfg_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int tcn;

    updown_mode_counter #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk(clk), .hard_rst_n(hard_rst_n), .soft_rst(soft_rst), .en(en),
        .up_dn(up_dn), .mode(mode), .low_val(low_val), .end_val(end_val),
        .prescale(prescale), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .cnt_out(cnt_out), .tc(tc), .done(done), .ovf(ovf), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int pre;
        bit done;
        bit ovf;
        bit tc;
    } mstate_t;

    mstate_t m = '{default: 0};

    // Next state from the counter rules, using plain integer arithmetic.
    function automatic mstate_t model_next(mstate_t s);
        mstate_t n;
        int lo, hi, ps, st, tv;
        bit term, ovf_set;
        n = s; lo = low_val; hi = end_val; ps = prescale;
        st = up_dn ? lo : hi;
        tv = up_dn ? hi : lo;
        ovf_set = 1'b0;
        n.tc = 1'b0;
        if (soft_rst) begin
            n.cnt = st; n.done = 1'b0; n.pre = 0;
        end else if (load) begin
            n.cnt = load_val; n.done = 1'b0; n.pre = 0;
        end else if (en && !s.done) begin
            n.pre = (s.pre == ps) ? 0 : (s.pre + 1) % (1 << PW);
            if (s.pre == ps && lo <= hi) begin
                term = (s.cnt < lo) || (s.cnt > hi) || (up_dn ? (s.cnt == hi) : (s.cnt == lo));
                if (term) begin
                    n.tc = 1'b1;
                    if (mode == 2'd2) begin
                        n.cnt = tv; n.done = 1'b1;
                    end else if (mode == 2'd1) begin
                        n.cnt = tv; ovf_set = 1'b1;
                    end else begin
                        n.cnt = st; ovf_set = 1'b1;
                    end
                end else begin
                    n.cnt = up_dn ? s.cnt + 1 : s.cnt - 1;
                end
            end
        end
        if (ovf_set) n.ovf = 1'b1;
        else if (clr_ovf) n.ovf = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge hard_rst_n) begin
        if (!hard_rst_n) m <= '{default: 0};
        else             m <= model_next(m);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model cnt",     32'(cnt_out), 32'(m.cnt));
            chk("model tc",      32'(tc),      32'(m.tc));
            chk("model done",    32'(done),    32'(m.done));
            chk("model ovf",     32'(ovf),     32'(m.ovf));
            chk("model cfg_err", 32'(cfg_err), 32'(low_val > end_val));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset cnt", 32'(cnt_out), 0);
        chk("reset tc", 32'(tc), 0);
        chk("reset done", 32'(done), 0);
        chk("reset ovf", 32'(ovf), 0);
        hard_rst_n = 1'b1;
        chk_en = 1'b1;

        // 1: up wrap 2..5
        soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
        chk("t1 start", 32'(cnt_out), 2);
        en = 1'b1;
        cyc(); chk("t1 cnt3", 32'(cnt_out), 3);
        cyc(); chk("t1 cnt4", 32'(cnt_out), 4);
        cyc(); chk("t1 cnt5", 32'(cnt_out), 5); chk("t1 tc@5", 32'(tc), 0);
        cyc(); chk("t1 wrap", 32'(cnt_out), 2); chk("t1 tc", 32'(tc), 1); chk("t1 ovf", 32'(ovf), 1);
        cyc(); chk("t1 cnt3b", 32'(cnt_out), 3); chk("t1 tc off", 32'(tc), 0);

        // 2: down saturate 3..9 from load 4
        mode = 2'b01; up_dn = 1'b0; low_val = 4'd3; end_val = 4'd9;
        load = 1'b1; load_val = 4'd4;
        cyc(); chk("t2 load", 32'(cnt_out), 4); chk("t2 load tc", 32'(tc), 0);
        load = 1'b0;
        cyc(); chk("t2 cnt3", 32'(cnt_out), 3); chk("t2 tc0", 32'(tc), 0);
        cyc(); chk("t2 sat", 32'(cnt_out), 3); chk("t2 tc1", 32'(tc), 1);
        cyc(); chk("t2 sat2", 32'(cnt_out), 3); chk("t2 tc2", 32'(tc), 1);
        en = 1'b0; clr_ovf = 1'b1;
        cyc(); chk("t2 clr ovf", 32'(ovf), 0);
        en = 1'b1;
        cyc(); chk("t2 set beats clr", 32'(ovf), 1);
        en = 1'b0;
        cyc(); chk("t2 clr ovf2", 32'(ovf), 0);
        clr_ovf = 1'b0;

        // 3: up one-shot 0..15, prescale 2
        mode = 2'b10; up_dn = 1'b1; low_val = 4'd0; end_val = 4'd15; prescale = 8'd2;
        soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
        chk("t3 start", 32'(cnt_out), 0);
        en = 1'b1;
        cyc(); cyc(); chk("t3 no step yet", 32'(cnt_out), 0);
        cyc(); chk("t3 first step", 32'(cnt_out), 1);
        tcn = 0;
        for (int i = 0; i < 45; i++) begin
            cyc();
            if (tc) tcn++;
        end
        chk("t3 end cnt", 32'(cnt_out), 15);
        chk("t3 done", 32'(done), 1);
        chk("t3 ovf untouched", 32'(ovf), 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tc) tcn++;
        end
        chk("t3 held", 32'(cnt_out), 15);
        chk("t3 single tc", 32'(tcn), 1);
        soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
        chk("t3 srst cnt", 32'(cnt_out), 0);
        chk("t3 srst done", 32'(done), 0);

        // 4: bound moved below the count, then inverted bounds, then low==end
        mode = 2'b00; low_val = 4'd2; prescale = 8'd0;
        load = 1'b1; load_val = 4'd7;
        cyc(); chk("t4 load7", 32'(cnt_out), 7);
        load = 1'b0; end_val = 4'd5;
        cyc(); chk("t4 wrap low", 32'(cnt_out), 2); chk("t4 tc", 32'(tc), 1);
        cyc(); chk("t4 cnt3", 32'(cnt_out), 3);
        low_val = 4'd6; end_val = 4'd5;
        #1; chk("t4 cfg_err", 32'(cfg_err), 1);
        repeat (3) cyc();
        chk("t4 frozen", 32'(cnt_out), 3); chk("t4 frozen tc", 32'(tc), 0);
        low_val = 4'd5; end_val = 4'd5;
        cyc(); chk("t4 eq oor", 32'(cnt_out), 5); chk("t4 eq tc", 32'(tc), 1);
        cyc(); chk("t4 eq fixed", 32'(cnt_out), 5); chk("t4 eq tc2", 32'(tc), 1);

        // 5: sync priority
        low_val = 4'd2; end_val = 4'd9;
        soft_rst = 1'b1; load = 1'b1; load_val = 4'd7;
        cyc(); chk("t5 srst wins", 32'(cnt_out), 2); chk("t5 srst tc", 32'(tc), 0);
        soft_rst = 1'b0; load_val = 4'd8;
        cyc(); chk("t5 load wins", 32'(cnt_out), 8); chk("t5 load tc", 32'(tc), 0);
        prescale = 8'd1;
        cyc(); chk("t5 load again", 32'(cnt_out), 8);
        load = 1'b0;
        cyc(); chk("t5 pre restart", 32'(cnt_out), 8);
        cyc(); chk("t5 step", 32'(cnt_out), 9);

        // 6: async reset between edges with a step pending
        low_val = 4'd0; end_val = 4'd15; prescale = 8'd2;
        soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
        repeat (5) cyc();
        chk("t6 pre-reset", 32'(cnt_out), 1);
        #2; hard_rst_n = 1'b0;
        #1;
        chk("t6 async cnt", 32'(cnt_out), 0);
        chk("t6 async ovf", 32'(ovf), 0);
        chk("t6 async tc", 32'(tc), 0);
        @(posedge clk); #1;
        hard_rst_n = 1'b1;
        cyc(); cyc(); chk("t6 waiting", 32'(cnt_out), 0);
        cyc(); chk("t6 resumed", 32'(cnt_out), 1);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
